// File: rtl/alu_rr_sched.sv
// -----------------------------------------------------------------------------
// alu_rr_sched
//
// Purpose:
//   Two-requester round-robin scheduler in front of one shared combinational
//   ALU. One operation is in flight at a time. Each operation is accepted,
//   executed for one cycle, and its registered result is returned to the
//   requester that issued it.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising clk edge where valid=1 and ready=1. The
//   producer holds valid and its payload stable until that edge. The consumer
//   may raise or lower ready freely.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   reqN_valid/ready/op/src1/src2  request channel for requester N (N=0,1)
//   rspN_valid/ready             response channel for requester N
//   rsp_data/rsp_overflow/rsp_err  response payload shared by both channels
//   alu_enable/op/src1/src2      drive to the shared ALU
//   alu_out/alu_overflow         result from the shared ALU
//
// Optional build macro ALU_SCHED_PERF_CNT_EN:
//   adds done0_cnt, done1_cnt, ovf_cnt (16-bit saturating completion and
//   overflow counters). Without the macro these ports do not exist.
// -----------------------------------------------------------------------------
module alu_rr_sched #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5,
   parameter int OP_MAX = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_src1,
   input  logic [DATA_W-1:0] req0_src2,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_src1,
   input  logic [DATA_W-1:0] req1_src2,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_overflow,
   output logic              rsp_err,
   output logic              alu_enable,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_overflow
`ifdef ALU_SCHED_PERF_CNT_EN
   ,
   output logic [15:0]       done0_cnt,
   output logic [15:0]       done1_cnt,
   output logic [15:0]       ovf_cnt
`endif
);

   localparam logic [OP_W-1:0] LP_OP_MAX = OP_W'(OP_MAX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic              r_last_grant;
   logic              r_id;
   logic              r_illegal;
   logic [OP_W-1:0]   r_op;
   logic [DATA_W-1:0] r_src1;
   logic [DATA_W-1:0] r_src2;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_ovf;
   logic              r_rsp_err;

   logic              w_pick0;
   logic              w_pick1;
   logic              w_accept;
   logic              w_rsp_hs;
   logic [OP_W-1:0]   w_sel_op;
   logic [DATA_W-1:0] w_sel_src1;
   logic [DATA_W-1:0] w_sel_src2;

   // Requester 1 wins when it is the only one asking, or when both ask and
   // requester 0 was served last. Otherwise requester 0 wins if it asks.
   assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);
   assign w_pick0 = req0_valid & ~w_pick1;

   assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign w_rsp_hs   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
   assign w_sel_op   = w_pick1 ? req1_op   : req0_op;
   assign w_sel_src1 = w_pick1 ? req1_src1 : req0_src1;
   assign w_sel_src2 = w_pick1 ? req1_src2 : req0_src2;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
         ST_EXEC: w_state_nxt = ST_RESP;
         ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Ready is also held low while reset is asserted so nothing looks accepted.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      alu_enable = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req0_ready = rst_n & w_pick0;
            req1_ready = rst_n & w_pick1;
         end
         ST_EXEC: alu_enable = ~r_illegal;
         ST_RESP: begin
            rsp0_valid = ~r_id;
            rsp1_valid = r_id;
         end
         default: ;
      endcase
   end

   // ALU operands come straight from the latched request, so they stay at
   // their last values outside EXEC instead of toggling.
   assign alu_op       = r_op;
   assign alu_src1     = r_src1;
   assign alu_src2     = r_src2;
   assign rsp_data     = r_rsp_data;
   assign rsp_overflow = r_rsp_ovf;
   assign rsp_err      = r_rsp_err;

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_illegal    <= 1'b0;
         r_op         <= '0;
         r_src1       <= '0;
         r_src2       <= '0;
         r_rsp_data   <= '0;
         r_rsp_ovf    <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && w_accept) begin
            r_op         <= w_sel_op;
            r_src1       <= w_sel_src1;
            r_src2       <= w_sel_src2;
            r_id         <= w_pick1;
            r_last_grant <= w_pick1;
            r_illegal    <= (w_sel_op > LP_OP_MAX);
         end
         if (r_state == ST_EXEC) begin
            r_rsp_data <= r_illegal ? '0 : alu_out;
            r_rsp_ovf  <= r_illegal ? 1'b0 : alu_overflow;
            r_rsp_err  <= r_illegal;
         end
      end
   end

`ifdef ALU_SCHED_PERF_CNT_EN
   logic [15:0] r_done0_cnt;
   logic [15:0] r_done1_cnt;
   logic [15:0] r_ovf_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done0_cnt <= '0;
         r_done1_cnt <= '0;
         r_ovf_cnt   <= '0;
      end else if (w_rsp_hs) begin
         if (!r_id && r_done0_cnt != 16'hFFFF) r_done0_cnt <= r_done0_cnt + 16'd1;
         if (r_id && r_done1_cnt != 16'hFFFF)  r_done1_cnt <= r_done1_cnt + 16'd1;
         if (r_rsp_ovf && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
   end

   assign done0_cnt = r_done0_cnt;
   assign done1_cnt = r_done1_cnt;
   assign ovf_cnt   = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_sched
//
// Bench for alu_rr_sched. Provides a behavioural ALU, drives requests at the
// falling clock edge and checks outputs just after it. A scoreboard process
// pushes the expected response on every request handshake and pops/compares on
// every response handshake.
// -----------------------------------------------------------------------------
module tb_alu_rr_sched;

   localparam int DW = 32;
   localparam int OW = 5;
   localparam int EW = 35;   // {id, err, ovf, data}

   logic          clk;
   logic          rst_n;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [OW-1:0] req0_op, req1_op;
   logic [DW-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready, rsp1_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_overflow, rsp_err;
   logic          alu_enable;
   logic [OW-1:0] alu_op;
   logic [DW-1:0] alu_src1, alu_src2, alu_out;
   logic          alu_overflow;
`ifdef ALU_SCHED_PERF_CNT_EN
   logic [15:0]   done0_cnt, done1_cnt, ovf_cnt;
`endif

   logic [EW-1:0] exp_q[$];
   int            n_cmp;
   int            n_fail;

   alu_rr_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_op      (req0_op),
      .req0_src1    (req0_src1),
      .req0_src2    (req0_src2),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_op      (req1_op),
      .req1_src1    (req1_src1),
      .req1_src2    (req1_src2),
      .rsp0_valid   (rsp0_valid),
      .rsp0_ready   (rsp0_ready),
      .rsp1_valid   (rsp1_valid),
      .rsp1_ready   (rsp1_ready),
      .rsp_data     (rsp_data),
      .rsp_overflow (rsp_overflow),
      .rsp_err      (rsp_err),
      .alu_enable   (alu_enable),
      .alu_op       (alu_op),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .alu_out      (alu_out),
      .alu_overflow (alu_overflow)
`ifdef ALU_SCHED_PERF_CNT_EN
      ,
      .done0_cnt    (done0_cnt),
      .done1_cnt    (done1_cnt),
      .ovf_cnt      (ovf_cnt)
`endif
   );

   // ------------------------------------------------------- clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------- behavioural ALU model
   // Returns {overflow, result}. Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR,
   // 4 XOR, 5 SLL, 6 SRL, others a mix of operands and opcode.
   function automatic logic [DW:0] alu_fn(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
      logic [DW-1:0] r;
      logic          v;
      v = 1'b0;
      case (op)
         5'd0: begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
         5'd1: begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
         5'd2: r = a & b;
         5'd3: r = a | b;
         5'd4: r = a ^ b;
         5'd5: r = a << b[4:0];
         5'd6: r = a >> b[4:0];
         default: r = a ^ b ^ {27'd0, op};
      endcase
      return {v, r};
   endfunction

   // A disabled ALU drives a poison value so a result captured without
   // enable is visible.
   always_comb begin
      if (alu_enable) {alu_overflow, alu_out} = alu_fn(alu_op, alu_src1, alu_src2);
      else            {alu_overflow, alu_out} = {1'b1, 32'hDEAD_BEEF};
   end

   // Expected {err, ovf, data} for a request, independent of the DUT.
   function automatic logic [DW+1:0] exp_res(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      if (op > 5'd17) return {1'b1, 1'b0, {DW{1'b0}}};
      return {1'b0, alu_fn(op, a, b)};
   endfunction

   // -------------------------------------------------------------- scoreboard
   always begin
      logic [EW-1:0] got;
      logic [EW-1:0] e;
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (req0_valid && req0_ready) exp_q.push_back({1'b0, exp_res(req0_op, req0_src1, req0_src2)});
         if (req1_valid && req1_ready) exp_q.push_back({1'b1, exp_res(req1_op, req1_src1, req1_src2)});
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            got = {rsp1_valid, rsp_err, rsp_overflow, rsp_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected_rsp: got %h, required no response", got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_fail++;
                  $display("FAIL sb_rsp: got {id,err,ovf,data}=%h required %h", got, e);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------- driver tasks
   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = '0; req0_src1 = '0; req0_src2 = '0;
      req1_op = '0; req1_src1 = '0; req1_src2 = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Raises valid for one requester, waits (bounded) for the handshake, then
   // drops valid. ok reports whether the handshake happened.
   task automatic send_req(input int id, input logic [OW-1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output bit ok);
      ok = 1'b0;
      @(negedge clk);
      if (id == 0) begin req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b; end
      else         begin req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b; end
      for (int k = 0; k < 20 && !ok; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         ok = (id == 0) ? req0_ready : req1_ready;
      end
      @(negedge clk);
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      req0_valid = 1'b1;   // ready must stay low while reset is held
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable, rsp_overflow, rsp_err} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 0000000",
                  {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable, rsp_overflow, rsp_err});
      end
      n_cmp++;
      if ({rsp_data, alu_op, alu_src1, alu_src2} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {rsp_data, alu_op, alu_src1, alu_src2});
      end
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 5'd0; req0_src1 = 32'd5; req0_src2 = 32'd7; rsp0_ready = 1'b1;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL single_accept: got ready %b required 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      n_cmp++;
      if ({alu_enable, alu_op, alu_src1, alu_src2, req0_ready} !== {1'b1, 5'd0, 32'd5, 32'd7, 1'b0}) begin
         n_fail++;
         $display("FAIL single_exec: got en=%b op=%h s1=%h s2=%h rdy=%b required 1/00/5/7/0",
                  alu_enable, alu_op, alu_src1, alu_src2, req0_ready);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({rsp0_valid, rsp1_valid, rsp_err, rsp_overflow, rsp_data, alu_enable} !== {4'b1000, 32'd12, 1'b0}) begin
         n_fail++;
         $display("FAIL single_resp: got v0=%b v1=%b err=%b ovf=%b data=%h en=%b required 1/0/0/0/0000000c/0",
                  rsp0_valid, rsp1_valid, rsp_err, rsp_overflow, rsp_data, alu_enable);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({rsp0_valid, alu_enable, alu_src1} !== {1'b0, 1'b0, 32'd5}) begin
         n_fail++;
         $display("FAIL single_after: got v0=%b en=%b s1=%h required 0/0/00000005", rsp0_valid, alu_enable, alu_src1);
      end
      drain("single");
   endtask

   task automatic test_alternate();
      int grants;
      int want;
      int got;
      do_reset();
      grants = 0;
      want   = 0;
      for (int c = 0; c < 40 && grants < 4; c++) begin
         @(negedge clk);
         if (c == 0) begin
            req0_valid = 1'b1; req0_op = 5'd1; req0_src1 = 32'd3; req0_src2 = 32'd5;
            req1_valid = 1'b1; req1_op = 5'd2; req1_src1 = 32'hF0F0_F0F0; req1_src2 = 32'h0FF0_0FF0;
         end
         #1;
         n_cmp++;
         if (req0_ready && req1_ready) begin
            n_fail++; $display("FAIL alt_both_ready: got 11 required at most one");
         end
         if (req0_ready || req1_ready) begin
            got = req1_ready ? 1 : 0;
            n_cmp++;
            if (got != want) begin
               n_fail++; $display("FAIL alt_grant: grant %0d got %0d required %0d", grants, got, want);
            end
            want = 1 - want;
            grants++;
         end
      end
      n_cmp++;
      if (grants != 4) begin
         n_fail++; $display("FAIL alt_grant_count: got %0d required 4", grants);
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain("alt");
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      rsp1_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 5'd0; req1_src1 = 32'h7FFF_FFFF; req1_src2 = 32'd1;
      #1;
      n_cmp++;
      if (req1_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_accept: got %b required 1", req1_ready);
      end
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 5'd3; req0_src1 = 32'h1234_0000; req0_src2 = 32'h0000_5678;
      #1;
      n_cmp++;
      if (req0_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_exec_ready: got %b required 0", req0_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) rsp1_ready = 1'b1;
         #1;
         n_cmp++;
         if ({rsp1_valid, rsp0_valid, rsp_data, rsp_overflow, req0_ready} !== {2'b10, 32'h8000_0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d got v1=%b v0=%b data=%h ovf=%b rdy0=%b required 1/0/80000000/1/0",
                     i, rsp1_valid, rsp0_valid, rsp_data, rsp_overflow, req0_ready);
         end
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({rsp1_valid, req0_ready} !== 2'b01) begin
         n_fail++; $display("FAIL bp_release: got v1,rdy0=%b required 01", {rsp1_valid, req0_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      drain("bp");
   endtask

   task automatic test_illegal();
      // Opcode 18 is the first illegal one; 17 is the last legal one.
      for (int t = 0; t < 2; t++) begin
         logic [OW-1:0] op;
         op = (t == 0) ? 5'd18 : 5'd17;
         @(negedge clk);
         req0_valid = 1'b1; req0_op = op; req0_src1 = $urandom; req0_src2 = $urandom;
         #1;
         n_cmp++;
         if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL ill_accept: op %0d got %b required 1", op, req0_ready);
         end
         @(negedge clk);
         req0_valid = 1'b0;
         #1;
         n_cmp++;
         if (alu_enable !== (t == 1)) begin
            n_fail++; $display("FAIL ill_enable: op %0d got %b required %0d", op, alu_enable, t);
         end
         @(negedge clk);
         #1;
         n_cmp++;
         if (t == 0 && {rsp0_valid, rsp_err, rsp_overflow, rsp_data, alu_enable} !== {3'b110, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ill_resp: got v0=%b err=%b ovf=%b data=%h en=%b required 1/1/0/00000000/0",
                     rsp0_valid, rsp_err, rsp_overflow, rsp_data, alu_enable);
         end
         if (t == 1 && {rsp0_valid, rsp_err} !== 2'b10) begin
            n_fail++; $display("FAIL max_resp: got v0,err=%b required 10", {rsp0_valid, rsp_err});
         end
         drain("ill");
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 5'd4; req0_src1 = 32'hAAAA_5555; req0_src2 = 32'h0F0F_0F0F;
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      n_cmp++;
      if (alu_enable !== 1'b1) begin
         n_fail++; $display("FAIL rmid_exec: got en=%b required 1", alu_enable);
      end
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      n_cmp++;
      if ({alu_enable, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_err, rsp_overflow, rsp_data, alu_op, alu_src1, alu_src2} !== '0) begin
         n_fail++;
         $display("FAIL rmid_async: got en=%b v0=%b v1=%b data=%h op=%h s1=%h s2=%h required all 0",
                  alu_enable, rsp0_valid, rsp1_valid, rsp_data, alu_op, alu_src1, alu_src2);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rmid_no_rsp: cycle %0d got %b required 00", i, {rsp0_valid, rsp1_valid});
         end
      end
      @(negedge clk);
      req0_valid = 1'b1; req0_op = 5'd0; req0_src1 = $urandom_range(0, 1000); req0_src2 = $urandom_range(0, 1000);
      req1_valid = 1'b1; req1_op = 5'd1; req1_src1 = $urandom_range(0, 1000); req1_src2 = $urandom_range(0, 1000);
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         n_fail++; $display("FAIL rmid_first_grant: got %b required 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain("rmid");
   endtask

   task automatic test_random();
      bit ok;
      for (int i = 0; i < 8; i++) begin
         int id;
         id = $urandom_range(0, 1);
         send_req(id, 5'($urandom_range(0, 19)), $urandom, $urandom, ok);
         n_cmp++;
         if (!ok) begin
            n_fail++; $display("FAIL rand_accept: op %0d got no handshake required one", i);
         end
      end
      drain("rand");
   endtask

`ifdef ALU_SCHED_PERF_CNT_EN
   task automatic test_perf_cnt();
      bit ok;
      do_reset();
      send_req(0, 5'd0, 32'h7FFF_FFFF, 32'd1, ok);
      send_req(0, 5'd0, 32'd1, 32'd1, ok);
      send_req(0, 5'd1, 32'h8000_0000, 32'd1, ok);
      drain("perf");
      #1;
      n_cmp++;
      if ({done0_cnt, done1_cnt, ovf_cnt} !== {16'd3, 16'd0, 16'd2}) begin
         n_fail++;
         $display("FAIL perf_cnt: got d0=%0d d1=%0d ovf=%0d required 3/0/2", done0_cnt, done1_cnt, ovf_cnt);
      end
   endtask
`endif

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- sequence
   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_single();
      test_alternate();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_random();
`ifdef ALU_SCHED_PERF_CNT_EN
      test_perf_cnt();
`endif
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL final_queue: got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
